bt656_active_tracker: RTL

- Sits directly downstream of sync_parser.
- Takes the 10-bit BT.656 stream together with the H/V/F levels that sync_parser produces.
- Produces registered active-video samples tagged with a sample index, active-line index and field.
- Checks every line against the 525/60 raster (1716 words/line, 1440 active words) and reports a lock status that downstream scrambler/descrambler stages gate on.

---
 rtl/bt656_pkg.sv | 24 ++
 rtl/bt656_active_tracker_if.sv | 30 +++
 rtl/bt656_line_checker.sv | 51 +++++
 rtl/bt656_active_tracker.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bt656_pkg.sv
// Shared constants, counter widths and tracker state encoding for the
// BT.656 525/60 active-video tracker.
package bt656_pkg;
    localparam int unsigned LINE_SAMPLES   = 1716;
    localparam int unsigned ACTIVE_SAMPLES = 1440;
    localparam int unsigned ACTIVE_LINES   = 244;
    localparam int unsigned LOCK_LINES     = 4;
    localparam int unsigned ERR_LIMIT      = 3;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned LINE_W = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } tracker_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/bt656_active_tracker_if.sv
// Video input (word + H/V/F levels) and tagged active-video output bundle.
interface bt656_active_tracker_if
    import bt656_pkg::*;
();
    logic [DATA_W-1:0] bt_656;
    logic              H;
    logic              V;
    logic              F;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  sample_idx;
    logic [LINE_W-1:0] line_idx;
    logic              field;
    logic              line_start;
    logic              frame_start;
    logic              locked;
    logic              line_err;

    modport master (
        output bt_656, H, V, F,
        input  data_out, data_valid, sample_idx, line_idx, field,
               line_start, frame_start, locked, line_err
    );

    modport slave (
        input  bt_656, H, V, F,
        output data_out, data_valid, sample_idx, line_idx, field,
               line_start, frame_start, locked, line_err
    );
endinterface

// File: rtl/bt656_line_checker.sv
// Per-line word counters and the good/bad line verdict taken at each H rise.
module bt656_line_checker
    import bt656_pkg::*;
#(
    parameter int unsigned LINE_SAMPLES   = bt656_pkg::LINE_SAMPLES,
    parameter int unsigned ACTIVE_SAMPLES = bt656_pkg::ACTIVE_SAMPLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             H,
    output logic             h_rise,
    output logic             h_fall,
    output logic             line_good,
    output logic [CNT_W-1:0] act_cnt
);
    logic             h_prev_q, h_prev_d;
    logic [CNT_W-1:0] tot_cnt_q, tot_cnt_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;

    // act_cnt_q counts active words already seen, so the falling-edge word
    // loads 1 and the count equals the line's active width at the next H rise.
    always_comb begin
        h_prev_d  = H;
        h_rise    = H && !h_prev_q;
        h_fall    = !H && h_prev_q;
        tot_cnt_d = h_rise ? '0 : sat_inc(tot_cnt_q);
        act_cnt_d = act_cnt_q;
        if (h_fall) begin
            act_cnt_d = CNT_W'(1);
        end else if (!H) begin
            act_cnt_d = sat_inc(act_cnt_q);
        end
        line_good = (32'(tot_cnt_q) + 32'd1 == LINE_SAMPLES) &&
                    (32'(act_cnt_q) == ACTIVE_SAMPLES);
    end

    assign act_cnt = act_cnt_q;

    // h_prev resets high so a release during blanking is not seen as an H rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_prev_q  <= 1'b1;
            tot_cnt_q <= '0;
            act_cnt_q <= '0;
        end else begin
            h_prev_q  <= h_prev_d;
            tot_cnt_q <= tot_cnt_d;
            act_cnt_q <= act_cnt_d;
        end
    end
endmodule

// File: rtl/bt656_active_tracker.sv
// Tracks 525/60 raster lock and emits registered active-video words tagged
// with sample index, active-line index and field.
module bt656_active_tracker
    import bt656_pkg::*;
#(
    parameter int unsigned LINE_SAMPLES   = bt656_pkg::LINE_SAMPLES,
    parameter int unsigned ACTIVE_SAMPLES = bt656_pkg::ACTIVE_SAMPLES,
    parameter int unsigned ACTIVE_LINES   = bt656_pkg::ACTIVE_LINES,
    parameter int unsigned LOCK_LINES     = bt656_pkg::LOCK_LINES,
    parameter int unsigned ERR_LIMIT      = bt656_pkg::ERR_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    bt656_active_tracker_if.slave   bus
);
    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);

    tracker_state_e    state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              v_prev_q, v_prev_d;
    logic [LINE_W-1:0] line_idx_q, line_idx_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]  sample_idx_q, sample_idx_d;
    logic              data_valid_q, data_valid_d;
    logic              field_q, field_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              locked_q, locked_d;
    logic              line_err_q, line_err_d;

    logic              h_rise, h_fall, line_good;
    logic [CNT_W-1:0]  act_cnt;

    bt656_line_checker #(
        .LINE_SAMPLES  (LINE_SAMPLES),
        .ACTIVE_SAMPLES(ACTIVE_SAMPLES)
    ) u_checker (
        .clk      (clk),
        .reset_n  (reset_n),
        .H        (bus.H),
        .h_rise   (h_rise),
        .h_fall   (h_fall),
        .line_good(line_good),
        .act_cnt  (act_cnt)
    );

    // Lock FSM; a rise seen in SEARCH only arms the check for the next line.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        line_err_d = 1'b0;
        if (h_rise) begin
            unique case (state_q)
                SEARCH: begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                    err_cnt_d  = '0;
                end
                ACQUIRE: begin
                    line_err_d = !line_good;
                    if (!line_good) begin
                        good_cnt_d = '0;
                    end else if (32'(good_cnt_q) + 32'd1 == LOCK_LINES) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                        err_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    line_err_d = !line_good;
                    if (line_good) begin
                        err_cnt_d = '0;
                    end else if (32'(err_cnt_q) + 32'd1 == ERR_LIMIT) begin
                        state_d    = SEARCH;
                        err_cnt_d  = '0;
                        good_cnt_d = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        v_prev_d   = bus.V;
        line_idx_d = line_idx_q;
        if (!bus.V && v_prev_q) begin
            line_idx_d = '0;
        end else if (h_rise && !bus.V && (32'(line_idx_q) < ACTIVE_LINES - 1)) begin
            line_idx_d = line_idx_q + LINE_W'(1);
        end

        if (h_fall) begin
            sample_idx_d = '0;
        end else if (32'(act_cnt) > ACTIVE_SAMPLES - 1) begin
            sample_idx_d = CNT_W'(ACTIVE_SAMPLES - 1);
        end else begin
            sample_idx_d = act_cnt;
        end

        data_out_d    = bus.bt_656;
        field_d       = bus.F;
        locked_d      = (state_q == LOCKED);
        data_valid_d  = locked_d && !bus.H && !bus.V;
        line_start_d  = data_valid_d && (sample_idx_d == '0);
        frame_start_d = line_start_d && (line_idx_d == '0) && !bus.F;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            err_cnt_q     <= '0;
            v_prev_q      <= 1'b1;
            line_idx_q    <= '0;
            data_out_q    <= '0;
            sample_idx_q  <= '0;
            data_valid_q  <= 1'b0;
            field_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
            v_prev_q      <= v_prev_d;
            line_idx_q    <= line_idx_d;
            data_out_q    <= data_out_d;
            sample_idx_q  <= sample_idx_d;
            data_valid_q  <= data_valid_d;
            field_q       <= field_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            line_err_q    <= line_err_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.sample_idx  = sample_idx_q;
    assign bus.line_idx    = line_idx_q;
    assign bus.field       = field_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.line_err    = line_err_q;
endmodule
